// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// Carries the decoded instruction word and ALU flags in, and all selects/strobes out.
interface multicycle_controller_if;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        pc_write;
  logic        ir_write;
  logic        mem_write;
  logic        reg_write;
  logic        adr_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_control;
  logic [1:0]  result_src;
  logic [1:0]  imm_src;
  logic [3:0]  state;
  logic [3:0]  flags;

  modport master (
    input  instr, alu_flags,
    output pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
           alu_src_b, alu_control, result_src, imm_src, state, flags
  );

  modport slave (
    output instr, alu_flags,
    input  pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
           alu_src_b, alu_control, result_src, imm_src, state, flags
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle ARM-subset datapath, including the NZCV flag register.
// Define COND_EXEC_EN to make DECODE honour the instruction's condition field.
module multicycle_controller (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  flags_q;
  logic [1:0]  op;
  logic        i_bit;
  logic [3:0]  cmd;
  logic        s_bit;
  logic        is_cmp;
  logic [1:0]  cmd_alu;
  logic        cond_ok;
  logic        pc_write_raw;
  logic        ir_write_raw;
  logic        mem_write_raw;
  logic        reg_write_raw;
  logic        unused_instr_bits;

  assign op     = bus.instr[27:26];
  assign i_bit  = bus.instr[25];
  assign cmd    = bus.instr[24:21];
  assign s_bit  = bus.instr[20];
  assign is_cmp = (cmd == 4'b1010);

`ifdef COND_EXEC_EN
  logic [3:0] cond;
  logic       flag_n, flag_z, flag_v;

  assign cond   = bus.instr[31:28];
  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[0];
  assign unused_instr_bits = ^{bus.instr[19:0], flags_q[1]};

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = ~flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ok = flag_z | (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
`else
  assign cond_ok = 1'b1;
  assign unused_instr_bits = ^{bus.instr[31:28], bus.instr[19:0]};
`endif

  // Unlisted data-processing commands fall back to ADD but still write back
  always_comb begin
    cmd_alu = 2'b00;
    case (cmd)
      4'b0100: cmd_alu = 2'b00;
      4'b0010: cmd_alu = 2'b01;
      4'b1010: cmd_alu = 2'b01;
      4'b0000: cmd_alu = 2'b10;
      4'b1100: cmd_alu = 2'b11;
      default: cmd_alu = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flags_q <= 4'b0000;
    else if ((state_q == EXECUTER || state_q == EXECUTEI) && (s_bit || is_cmp))
      flags_q <= bus.alu_flags;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        if (!cond_ok)        state_d = FETCH;
        else begin
          case (op)
            2'b01:   state_d = MEMADR;
            2'b00:   state_d = i_bit ? EXECUTEI : EXECUTER;
            2'b10:   state_d = BRANCH;
            default: state_d = FETCH;
          endcase
        end
      end
      MEMADR:   state_d = s_bit ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // Strobes are computed raw here and gated by reset below so an abort issues nothing
  always_comb begin
    pc_write_raw    = 1'b0;
    ir_write_raw    = 1'b0;
    mem_write_raw   = 1'b0;
    reg_write_raw   = 1'b0;
    bus.adr_src     = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.alu_control = 2'b00;
    bus.result_src  = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write_raw   = 1'b1;
        pc_write_raw   = 1'b1;
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
      end
      DECODE: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
      end
      MEMADR:   bus.alu_src_b = 2'b01;
      MEMREAD:  bus.adr_src   = 1'b1;
      MEMWB: begin
        bus.result_src = 2'b01;
        reg_write_raw  = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src   = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTER: begin
        bus.alu_src_b   = 2'b00;
        bus.alu_control = cmd_alu;
      end
      EXECUTEI: begin
        bus.alu_src_b   = 2'b01;
        bus.alu_control = cmd_alu;
      end
      ALUWB:    reg_write_raw = ~is_cmp;
      BRANCH: begin
        bus.alu_src_b  = 2'b01;
        bus.result_src = 2'b10;
        pc_write_raw   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_write  = pc_write_raw  & ~reset;
  assign bus.ir_write  = ir_write_raw  & ~reset;
  assign bus.mem_write = mem_write_raw & ~reset;
  assign bus.reg_write = reg_write_raw & ~reset;
  assign bus.imm_src   = (op == 2'b11) ? 2'b00 : op;
  assign bus.state     = state_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction cycle traces are predicted
// from the instruction class and compared by a negedge monitor against the DUT outputs.
`timescale 1ns/1ps
module tb_multicycle_controller;

  typedef logic [21:0] obs_t;
  typedef struct {
    obs_t v;
    int   idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   instr_idx = 0;
  logic [3:0] model_flags;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic obs_t observe();
    return {bus.state, bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write,
            bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
            bus.result_src, bus.imm_src, bus.flags};
  endfunction

  function automatic obs_t mk(input logic [3:0] st, input logic pcw, input logic irw,
                              input logic mw, input logic rw, input logic adr,
                              input logic srca, input logic [1:0] srcb,
                              input logic [1:0] alu, input logic [1:0] res,
                              input logic [1:0] imm, input logic [3:0] fl);
    return {st, pcw, irw, mw, rw, adr, srca, srcb, alu, res, imm, fl};
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] c);
    case (c)
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b1010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
    bit n, z, v;
    n = f[3];
    z = f[2];
    v = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (c == c) || (f == f);
`endif
  endfunction

  task automatic push(input obs_t v);
    exp_t e;
    e.v   = v;
    e.idx = instr_idx;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Predict the complete cycle trace of one instruction, then let it run to the next FETCH
  task automatic applyStimulus(input logic [31:0] ins, input logic [3:0] af);
    logic [1:0] op;
    logic [1:0] imm;
    logic [3:0] cmd;
    logic [3:0] f;
    int n;
    op  = ins[27:26];
    cmd = ins[24:21];
    imm = (op == 2'b11) ? 2'b00 : op;
    f   = model_flags;
    bus.instr     = ins;
    bus.alu_flags = af;
    push(mk(4'd0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, f));
    push(mk(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, f));
    n = 2;
    if (op != 2'b11 && cond_holds(ins[31:28], f)) begin
      case (op)
        2'b01: begin
          push(mk(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, imm, f));
          if (ins[20]) begin
            push(mk(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, imm, f));
            push(mk(4'd4, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, imm, f));
            n = 5;
          end else begin
            push(mk(4'd5, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, imm, f));
            n = 4;
          end
        end
        2'b00: begin
          push(mk(ins[25] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 0, ins[25] ? 2'b01 : 2'b00,
                  alu_of(cmd), 2'b00, imm, f));
          if (ins[20] || cmd == 4'b1010) f = af;
          push(mk(4'd8, 0, 0, 0, cmd != 4'b1010, 0, 0, 2'b00, 2'b00, 2'b00, imm, f));
          n = 4;
        end
        default: begin
          push(mk(4'd9, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, imm, f));
          n = 3;
        end
      endcase
    end
    model_flags = f;
    instr_idx++;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start a store, abort it with reset while in MEMWRITE, then release into FETCH
  task automatic resetDuringStore();
    bus.instr     = 32'hE5810004;
    bus.alu_flags = 4'b0000;
    push(mk(4'd0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, model_flags));
    push(mk(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, model_flags));
    push(mk(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, model_flags));
    instr_idx++;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("memwrite_before_reset", {bus.state, bus.mem_write}, {4'd5, 1'b1});
    #1 reset = 1'b1;
    model_flags = 4'b0000;
    #1;
    checkOutput("abort_mem_write", bus.mem_write, 1'b0);
    checkOutput("abort_state", bus.state, 4'd0);
    checkOutput("abort_flags", bus.flags, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("abort_strobes_held", {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write}, 4'b0000);
    reset = 1'b0;
    #1;
    checkOutput("release_fetch_strobes", {bus.pc_write, bus.ir_write}, 2'b11);
  endtask

  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput($sformatf("instr%0d_state%0d", mon_e.idx, mon_e.v[21:18]), observe(), mon_e.v);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    logic [3:0]  cond, cmd;
    int kind;
    reset         = 1'b1;
    bus.instr     = 32'h0;
    bus.alu_flags = 4'h0;
    model_flags   = 4'h0;
    #1;
    checkOutput("reset_state", bus.state, 4'd0);
    checkOutput("reset_flags", bus.flags, 4'b0000);
    checkOutput("reset_strobes", {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write}, 4'b0000);
    checkOutput("reset_fetch_selects",
                {bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.result_src},
                {1'b0, 1'b1, 2'b10, 2'b00, 2'b10});
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("first_fetch_strobes", {bus.pc_write, bus.ir_write}, 2'b11);

    $display("[TB] directed instructions");
    applyStimulus(32'hE2810005, 4'b1111);
    applyStimulus(32'hE5910004, 4'b0000);
    applyStimulus(32'hE5810004, 4'b0000);
    applyStimulus(32'hE1510002, 4'b0100);
    checkOutput("cmp_flags", bus.flags, 4'b0100);
    applyStimulus(32'h1A000003, 4'b0000);
    applyStimulus(32'hEC000000, 4'b1010);
    applyStimulus(32'hE1510002, 4'b1001);
    resetDuringStore();

    $display("[TB] randomized instructions");
    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 5);
      cond = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
      case ($urandom_range(0, 5))
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b1010;
        3: cmd = 4'b0000;
        4: cmd = 4'b1100;
        default: cmd = 4'($urandom_range(0, 15));
      endcase
      case (kind)
        0, 1:    ins = {cond, 2'b00, 1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1)), 20'($urandom)};
        2:       ins = {cond, 2'b01, 6'($urandom), 20'($urandom)};
        3:       ins = {cond, 2'b10, 26'($urandom)};
        4:       ins = {cond, 2'b11, 26'($urandom)};
        default: ins = {cond, 2'b00, 1'($urandom_range(0, 1)), 4'b1010, 1'b1, 20'($urandom)};
      endcase
      applyStimulus(ins, 4'($urandom_range(0, 15)));
    end

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
